// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the line memory port with serial-tagged read response steering
module mem_port_arbiter #(
  parameter int REQ_NUM = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int SERIAL_WIDTH = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQ_NUM-1:0]               req_valid,
  input  logic [REQ_NUM-1:0]               req_is_write,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0]    req_addr,
  input  logic [REQ_NUM*LINE_WIDTH-1:0]    req_wdata,
  output logic [REQ_NUM-1:0]               req_ack,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_is_write,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [LINE_WIDTH-1:0]            mem_req_wdata,
  output logic [SERIAL_WIDTH-1:0]          mem_req_serial,
  input  logic                             mem_rsp_valid,
  input  logic [SERIAL_WIDTH-1:0]          mem_rsp_serial,
  input  logic [LINE_WIDTH-1:0]            mem_rsp_data,
  output logic [REQ_NUM-1:0]               rsp_valid,
  output logic [LINE_WIDTH-1:0]            rsp_data,
  output logic                             rsp_error
);
  localparam int IW = REQ_NUM > 1 ? $clog2(REQ_NUM) : 1;
  localparam int TW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  logic [IW-1:0] ptr, gnt_idx;
  logic gnt_found, gnt, gnt_wr, hit_any, rd_ok, stage_free;
  logic [SERIAL_WIDTH-1:0] serial_cnt;
  logic [MAX_OUTSTANDING-1:0] tbl_valid, hit, avail;
  logic [SERIAL_WIDTH-1:0] tbl_serial [MAX_OUTSTANDING];
  logic [IW-1:0] tbl_id [MAX_OUTSTANDING];
  logic [TW-1:0] hit_idx, alloc_idx;
  logic [REQ_NUM-1:0] elig;
  // Serial CAM for returning reads; an entry retiring this cycle counts as free for a new read
  always_comb begin
    hit = '0;
    avail = '0;
    hit_idx = '0;
    alloc_idx = '0;
    for (int e = MAX_OUTSTANDING-1; e >= 0; e--) begin
      hit[e] = mem_rsp_valid && tbl_valid[e] && tbl_serial[e] == mem_rsp_serial;
      avail[e] = !tbl_valid[e] || hit[e];
      if (hit[e]) hit_idx = TW'(e);
      if (avail[e]) alloc_idx = TW'(e);
    end
  end
  assign hit_any = |hit;
  assign rd_ok = |avail;
  assign stage_free = !mem_req_valid || mem_req_ready;
  assign elig = req_valid & (req_is_write | {REQ_NUM{rd_ok}});
  // First eligible requester at or after the round-robin pointer, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int k = REQ_NUM-1; k >= 0; k--)
      if (elig[(int'(ptr) + k) % REQ_NUM]) begin
        gnt_found = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % REQ_NUM);
      end
  end
  assign gnt = !rst && stage_free && gnt_found;
  assign gnt_wr = req_is_write[gnt_idx];
  assign req_ack = gnt ? REQ_NUM'(1) << gnt_idx : '0;
  // Output request stage: refills on the consuming edge, holds while stalled
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_is_write <= 1'b0;
      mem_req_addr <= '0;
      mem_req_wdata <= '0;
      mem_req_serial <= '0;
      serial_cnt <= '0;
      ptr <= '0;
    end else if (gnt) begin
      mem_req_valid <= 1'b1;
      mem_req_is_write <= gnt_wr;
      mem_req_addr <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_req_wdata <= req_wdata[gnt_idx*LINE_WIDTH +: LINE_WIDTH];
      mem_req_serial <= serial_cnt;
      serial_cnt <= gnt_wr ? serial_cnt : serial_cnt + 1'b1;
      ptr <= gnt_idx == IW'(REQ_NUM-1) ? '0 : gnt_idx + 1'b1;
    end else if (mem_req_ready) mem_req_valid <= 1'b0;
  // Outstanding read table: free on matching response, allocate lowest free entry on read grant
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tbl_valid <= '0;
      for (int e = 0; e < MAX_OUTSTANDING; e++) begin
        tbl_serial[e] <= '0;
        tbl_id[e] <= '0;
      end
    end else begin
      if (hit_any) tbl_valid[hit_idx] <= 1'b0;
      if (gnt && !gnt_wr) begin
        tbl_valid[alloc_idx] <= 1'b1;
        tbl_serial[alloc_idx] <= serial_cnt;
        tbl_id[alloc_idx] <= gnt_idx;
      end
    end
  // Registered response steering and sticky error on unmatched serial
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= hit_any ? REQ_NUM'(1) << tbl_id[hit_idx] : '0;
      if (hit_any) rsp_data <= mem_rsp_data;
      rsp_error <= rsp_error || (mem_rsp_valid && !hit_any);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] req_valid = '0, req_is_write = '0, req_ack, rsp_valid;
  logic [95:0] req_addr = '0;
  logic [383:0] req_wdata = '0;
  logic mem_req_valid, mem_req_ready = 1'b1, mem_req_is_write, mem_rsp_valid = 1'b0, rsp_error;
  logic [31:0] mem_req_addr;
  logic [127:0] mem_req_wdata, mem_rsp_data = '0, rsp_data;
  logic [3:0] mem_req_serial, mem_rsp_serial = '0;
  int total = 0, bad = 0;
  int ord[6] = '{2, 0, 1, 2, 0, 1};
  int s5[4] = '{12, 10, 9, 13};
  int id5[4] = '{0, 1, 0, 1};
  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_is_write(mem_req_is_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_serial(mem_req_serial),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_serial(mem_rsp_serial),
    .mem_rsp_data(mem_rsp_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_error(rsp_error)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    req_addr[0 +: 32] = 32'h0000_3000;
    req_addr[32 +: 32] = 32'h0000_1000;
    req_addr[64 +: 32] = 32'h0000_5000;
    step;
    step;
    chk("rst_mem_req_valid", 128'(mem_req_valid), 128'd0);
    chk("rst_req_ack", 128'(req_ack), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_rsp_error", 128'(rsp_error), 128'd0);
    rst = 1'b0;
    req_valid = 3'b010;
    #1;
    chk("s1_ack", 128'(req_ack), 128'b010);
    step;
    req_valid = 3'b000;
    chk("s1_valid", 128'(mem_req_valid), 128'd1);
    chk("s1_addr", 128'(mem_req_addr), 128'h1000);
    chk("s1_serial", 128'(mem_req_serial), 128'd0);
    chk("s1_is_write", 128'(mem_req_is_write), 128'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_serial = 4'd0;
    mem_rsp_data = {16{8'hA5}};
    step;
    mem_rsp_valid = 1'b0;
    chk("s1_rsp_valid", 128'(rsp_valid), 128'b010);
    chk("s1_rsp_data", rsp_data, {16{8'hA5}});
    chk("s1_drained", 128'(mem_req_valid), 128'd0);
    step;
    chk("s1_rsp_clear", 128'(rsp_valid), 128'd0);
    req_valid = 3'b111;
    for (int n = 0; n < 6; n++) begin
      if (n > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_serial = 4'(n);
        mem_rsp_data = 128'(n + 100);
      end
      #1;
      chk("s2_ack", 128'(req_ack), 128'(3'b001 << ord[n]));
      if (n > 0) begin
        chk("s2_valid", 128'(mem_req_valid), 128'd1);
        chk("s2_serial", 128'(mem_req_serial), 128'(n));
      end
      if (n > 1) chk("s2_rsp", 128'(rsp_valid), 128'(3'b001 << ord[n-2]));
      step;
    end
    req_valid = 3'b000;
    mem_rsp_serial = 4'd6;
    #1;
    chk("s2_last_serial", 128'(mem_req_serial), 128'd6);
    chk("s2_rsp4", 128'(rsp_valid), 128'(3'b001 << ord[4]));
    step;
    mem_rsp_valid = 1'b0;
    chk("s2_rsp5", 128'(rsp_valid), 128'(3'b001 << ord[5]));
    chk("s2_idle", 128'(mem_req_valid), 128'd0);
    mem_req_ready = 1'b0;
    req_valid = 3'b001;
    req_is_write = 3'b001;
    req_addr[0 +: 32] = 32'h0000_2000;
    req_wdata[0 +: 128] = {4{32'hDEAD_BEEF}};
    #1;
    chk("s3_wr_ack", 128'(req_ack), 128'b001);
    step;
    req_valid = 3'b110;
    req_is_write = 3'b000;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("s3_hold_ack", 128'(req_ack), 128'd0);
      chk("s3_hold_valid", 128'(mem_req_valid), 128'd1);
      chk("s3_hold_wr", 128'(mem_req_is_write), 128'd1);
      chk("s3_hold_addr", 128'(mem_req_addr), 128'h2000);
      chk("s3_hold_wdata", mem_req_wdata, {4{32'hDEAD_BEEF}});
      chk("s3_hold_serial", 128'(mem_req_serial), 128'd7);
      step;
    end
    mem_req_ready = 1'b1;
    #1;
    chk("s3_rr_ack1", 128'(req_ack), 128'b010);
    step;
    req_valid = 3'b100;
    chk("s3_rd1_addr", 128'(mem_req_addr), 128'h1000);
    chk("s3_rd1_serial", 128'(mem_req_serial), 128'd7);
    chk("s3_rd1_wr", 128'(mem_req_is_write), 128'd0);
    #1;
    chk("s3_rr_ack2", 128'(req_ack), 128'b100);
    step;
    req_valid = 3'b000;
    chk("s3_rd2_addr", 128'(mem_req_addr), 128'h5000);
    chk("s3_rd2_serial", 128'(mem_req_serial), 128'd8);
    mem_rsp_valid = 1'b1;
    mem_rsp_serial = 4'd7;
    step;
    chk("s3_rsp7", 128'(rsp_valid), 128'b010);
    mem_rsp_serial = 4'd8;
    step;
    mem_rsp_valid = 1'b0;
    chk("s3_rsp8", 128'(rsp_valid), 128'b100);
    req_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      #1;
      chk("s4_ack", 128'(req_ack), 128'(3'b001 << (n % 3)));
      if (n > 0) chk("s4_serial", 128'(mem_req_serial), 128'(8 + n));
      step;
    end
    #1;
    chk("s4_full_ack", 128'(req_ack), 128'd0);
    chk("s4_serial12", 128'(mem_req_serial), 128'd12);
    step;
    chk("s4_full_ack2", 128'(req_ack), 128'd0);
    chk("s4_drained", 128'(mem_req_valid), 128'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_serial = 4'd11;
    mem_rsp_data = 128'h11;
    #1;
    chk("s4_free_ack", 128'(req_ack), 128'b010);
    step;
    req_valid = 3'b000;
    mem_rsp_valid = 1'b0;
    chk("s4_rsp11", 128'(rsp_valid), 128'b100);
    chk("s4_serial13", 128'(mem_req_serial), 128'd13);
    chk("s4_addr13", 128'(mem_req_addr), 128'h1000);
    for (int n = 0; n < 4; n++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_serial = 4'(s5[n]);
      mem_rsp_data = {4{32'(32'hC0DE_0000 + n)}};
      step;
      chk("s5_rsp_valid", 128'(rsp_valid), 128'(3'b001 << id5[n]));
      chk("s5_rsp_data", rsp_data, {4{32'(32'hC0DE_0000 + n)}});
      chk("s5_no_err", 128'(rsp_error), 128'd0);
    end
    mem_rsp_serial = 4'd9;
    step;
    mem_rsp_valid = 1'b0;
    chk("s5_stray_rsp", 128'(rsp_valid), 128'd0);
    chk("s5_stray_err", 128'(rsp_error), 128'd1);
    step;
    chk("s5_err_sticky", 128'(rsp_error), 128'd1);
    req_valid = 3'b011;
    #1;
    chk("s6_ack0", 128'(req_ack), 128'b001);
    step;
    req_valid = 3'b010;
    #1;
    chk("s6_ack1", 128'(req_ack), 128'b010);
    step;
    chk("s6_pre_serial", 128'(mem_req_serial), 128'd15);
    chk("s6_pre_valid", 128'(mem_req_valid), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_async_valid", 128'(mem_req_valid), 128'd0);
    chk("s6_async_ack", 128'(req_ack), 128'd0);
    chk("s6_async_rsp", 128'(rsp_valid), 128'd0);
    chk("s6_async_err", 128'(rsp_error), 128'd0);
    #1;
    rst = 1'b0;
    req_valid = 3'b100;
    #1;
    chk("s6_post_ack", 128'(req_ack), 128'b100);
    step;
    req_valid = 3'b000;
    chk("s6_post_serial", 128'(mem_req_serial), 128'd0);
    chk("s6_post_addr", 128'(mem_req_addr), 128'h5000);
    step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end
endmodule
